// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: CPU, DMA and memory-macro signals around the shared-memory arbiter.
// Signal prefixes are from the arbiter's side: i_ enters the arbiter, o_ leaves it.
interface mem_bus_arbiter_if #(
    parameter int MEMORY_WIDTH = 16
);
    logic                    i_cpu_req;
    logic [31:0]             i_cpu_addr;
    logic [31:0]             i_cpu_wdata;
    logic [3:0]              i_cpu_wb;
    logic [31:0]             o_cpu_rdata;
    logic                    o_cpu_stall;
    logic                    i_dma_req;
    logic                    i_dma_we;
    logic [31:0]             i_dma_addr;
    logic [31:0]             i_dma_wdata;
    logic                    o_dma_gnt;
    logic                    o_dma_valid;
    logic [31:0]             o_dma_rdata;
    logic                    o_mem_en;
    logic [3:0]              o_mem_wb;
    logic [MEMORY_WIDTH-1:0] o_mem_addr;
    logic [31:0]             o_mem_wdata;
    logic [31:0]             i_mem_rdata;

    modport slave (
        input  i_cpu_req, i_cpu_addr, i_cpu_wdata, i_cpu_wb,
        output o_cpu_rdata, o_cpu_stall,
        input  i_dma_req, i_dma_we, i_dma_addr, i_dma_wdata,
        output o_dma_gnt, o_dma_valid, o_dma_rdata,
        output o_mem_en, o_mem_wb, o_mem_addr, o_mem_wdata,
        input  i_mem_rdata
    );

    modport master (
        output i_cpu_req, i_cpu_addr, i_cpu_wdata, i_cpu_wb,
        input  o_cpu_rdata, o_cpu_stall,
        output i_dma_req, i_dma_we, i_dma_addr, i_dma_wdata,
        input  o_dma_gnt, o_dma_valid, o_dma_rdata,
        input  o_mem_en, o_mem_wb, o_mem_addr, o_mem_wdata,
        output i_mem_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port synchronous memory between the CPU (default owner) and a DMA requester.
// DMA bursts are bounded; at the limit a waiting CPU gets CPU_SLOT cycles before DMA may return.
module mem_bus_arbiter #(
    parameter int MEMORY_WIDTH  = 16,
    parameter int DMA_MAX_BURST = 16,
    parameter int CPU_SLOT      = 1
) (
    input logic                 i_clk,
    input logic                 i_rst,
    mem_bus_arbiter_if.slave    bus
);
    localparam int BW = (DMA_MAX_BURST > 1) ? $clog2(DMA_MAX_BURST) : 1;
    localparam int SW = $clog2(CPU_SLOT + 1);

    typedef enum logic {S_CPU, S_DMA} state_t;

    state_t          r_state;
    logic [BW-1:0]   r_burst_cnt;
    logic [SW-1:0]   r_slot_cnt;
    logic            r_rd_cpu;
    logic            r_rd_dma;
    logic [31:0]     r_cpu_rdata;
    logic            w_dma;
    logic            w_gnt;
    logic            w_last;
    logic [SW-1:0]   w_slot_nxt;

    always_comb begin
        w_dma      = r_state == S_DMA;
        w_gnt      = w_dma && bus.i_dma_req;
        w_last     = r_burst_cnt == BW'(DMA_MAX_BURST - 1);
        w_slot_nxt = (r_slot_cnt != '0) ? r_slot_cnt - 1'b1 : '0;
    end

    assign bus.o_mem_en    = !i_rst && (w_dma ? bus.i_dma_req : bus.i_cpu_req);
    assign bus.o_mem_wb    = i_rst ? 4'h0 : w_dma ? {4{bus.i_dma_we}} : bus.i_cpu_wb;
    assign bus.o_mem_addr  = w_dma ? bus.i_dma_addr[MEMORY_WIDTH+1:2] : bus.i_cpu_addr[MEMORY_WIDTH+1:2];
    assign bus.o_mem_wdata = w_dma ? bus.i_dma_wdata : bus.i_cpu_wdata;
    assign bus.o_cpu_stall = i_rst || w_dma;
    assign bus.o_dma_gnt   = w_gnt;
    assign bus.o_dma_valid = r_rd_dma;
    assign bus.o_dma_rdata = bus.i_mem_rdata;
    // A CPU read issued in the last CPU cycle stays visible for the whole DMA window.
    assign bus.o_cpu_rdata = r_rd_cpu ? bus.i_mem_rdata : r_cpu_rdata;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_CPU;
            r_burst_cnt <= '0;
            r_slot_cnt  <= '0;
            r_rd_cpu    <= 1'b0;
            r_rd_dma    <= 1'b0;
            r_cpu_rdata <= '0;
        end else begin
            r_rd_cpu <= !w_dma && bus.i_cpu_req && bus.i_cpu_wb == 4'h0;
            r_rd_dma <= w_gnt && !bus.i_dma_we;
            if (r_rd_cpu)
                r_cpu_rdata <= bus.i_mem_rdata;
            if (!w_dma) begin
                // Handover once this cycle has used up the last owed CPU slot.
                r_slot_cnt <= w_slot_nxt;
                if (bus.i_dma_req && w_slot_nxt == '0) begin
                    r_state     <= S_DMA;
                    r_burst_cnt <= '0;
                end
            end else if (!bus.i_dma_req) begin
                r_state <= S_CPU;
            end else begin
                r_burst_cnt <= w_last ? '0 : r_burst_cnt + 1'b1;
                if (w_last && bus.i_cpu_req) begin
                    r_state    <= S_CPU;
                    r_slot_cnt <= SW'(CPU_SLOT);
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of ownership, burst limit, CPU slot, read return and async reset.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] mem [0:1023];

    mem_bus_arbiter_if #(.MEMORY_WIDTH(16)) bus();

    mem_bus_arbiter #(.MEMORY_WIDTH(16), .DMA_MAX_BURST(16), .CPU_SLOT(1)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.o_mem_en) begin
            if (bus.o_mem_wb == 4'h0)
                bus.i_mem_rdata <= mem[bus.o_mem_addr[9:0]];
            else
                for (int b = 0; b < 4; b++)
                    if (bus.o_mem_wb[b])
                        mem[bus.o_mem_addr[9:0]][8*b +: 8] <= bus.o_mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        mem[4]  <= 32'hCAFEF00D;
        mem[8]  <= 32'h12345678;
        mem[16] <= 32'hDEADBEEF;
        mem[17] <= 32'h0BADF00D;
        bus.i_cpu_req   = 1'b1;
        bus.i_cpu_addr  = 32'h10;
        bus.i_cpu_wdata = 32'h0;
        bus.i_cpu_wb    = 4'h3;
        bus.i_dma_req   = 1'b0;
        bus.i_dma_we    = 1'b0;
        bus.i_dma_addr  = 32'h0;
        bus.i_dma_wdata = 32'h0;
        #2;
        chk("rst_stall", bus.o_cpu_stall, 1);
        chk("rst_mem_en", bus.o_mem_en, 0);
        chk("rst_mem_wb", bus.o_mem_wb, 0);
        chk("rst_gnt", bus.o_dma_gnt, 0);
        chk("rst_valid", bus.o_dma_valid, 0);
        chk("rst_cpu_data", bus.o_cpu_rdata, 0);

        // CPU read without DMA
        tick;
        rst = 1'b0;
        bus.i_cpu_wb = 4'h0;
        #1;
        chk("t1_stall", bus.o_cpu_stall, 0);
        chk("t1_mem_en", bus.o_mem_en, 1);
        chk("t1_mem_addr", bus.o_mem_addr, 32'h4);
        tick;
        bus.i_cpu_req = 1'b0;
        #1;
        chk("t1_cpu_data", bus.o_cpu_rdata, 32'hCAFEF00D);
        chk("t1_stall2", bus.o_cpu_stall, 0);
        tick;
        #1;
        chk("t1_cpu_hold", bus.o_cpu_rdata, 32'hCAFEF00D);

        // Simultaneous CPU read and DMA request
        tick;
        bus.i_cpu_req   = 1'b1;
        bus.i_cpu_addr  = 32'h20;
        bus.i_dma_req   = 1'b1;
        bus.i_dma_we    = 1'b1;
        bus.i_dma_addr  = 32'h80;
        bus.i_dma_wdata = 32'h11111111;
        #1;
        chk("t2_stall0", bus.o_cpu_stall, 0);
        chk("t2_cpu_addr", bus.o_mem_addr, 32'h8);
        chk("t2_gnt0", bus.o_dma_gnt, 0);
        tick;
        #1;
        chk("t2_stall1", bus.o_cpu_stall, 1);
        chk("t2_gnt1", bus.o_dma_gnt, 1);
        chk("t2_mem_wb", bus.o_mem_wb, 32'hF);
        chk("t2_dma_addr", bus.o_mem_addr, 32'h20);
        chk("t2_cpu_data", bus.o_cpu_rdata, 32'h12345678);
        tick;
        bus.i_dma_req = 1'b0;
        #1;
        chk("t2_stall2", bus.o_cpu_stall, 1);
        chk("t2_gnt2", bus.o_dma_gnt, 0);
        chk("t2_mem_en", bus.o_mem_en, 0);
        chk("t2_cpu_keep", bus.o_cpu_rdata, 32'h12345678);
        chk("t2_mem_write", mem[32], 32'h11111111);
        tick;
        bus.i_cpu_req = 1'b0;
        #1;
        chk("t2_stall3", bus.o_cpu_stall, 0);
        chk("t2_cpu_keep2", bus.o_cpu_rdata, 32'h12345678);

        // 16-word DMA burst with CPU waiting: forced one-cycle CPU slot
        tick;
        bus.i_cpu_req   = 1'b1;
        bus.i_cpu_addr  = 32'h10;
        bus.i_dma_req   = 1'b1;
        bus.i_dma_we    = 1'b1;
        bus.i_dma_addr  = 32'h100;
        bus.i_dma_wdata = 32'hA0000000;
        #1;
        chk("t3_pre_gnt", bus.o_dma_gnt, 0);
        for (int k = 0; k < 16; k++) begin
            tick;
            bus.i_dma_addr  = 32'h100 + 4 * k;
            bus.i_dma_wdata = 32'hA0000000 + k;
            #1;
            chk("t3_gnt", bus.o_dma_gnt, 1);
            chk("t3_stall", bus.o_cpu_stall, 1);
            chk("t3_addr", bus.o_mem_addr, 32'h40 + k);
        end
        tick;
        bus.i_dma_addr  = 32'h140;
        bus.i_dma_wdata = 32'hA0000010;
        #1;
        chk("t3_slot_stall", bus.o_cpu_stall, 0);
        chk("t3_slot_gnt", bus.o_dma_gnt, 0);
        chk("t3_slot_addr", bus.o_mem_addr, 32'h4);
        chk("t3_slot_en", bus.o_mem_en, 1);
        chk("t3_first_word", mem[64], 32'hA0000000);
        chk("t3_last_word", mem[79], 32'hA000000F);
        tick;
        #1;
        chk("t3_regain_gnt", bus.o_dma_gnt, 1);
        chk("t3_regain_stall", bus.o_cpu_stall, 1);
        chk("t3_regain_addr", bus.o_mem_addr, 32'h50);
        tick;
        bus.i_dma_req = 1'b0;
        bus.i_cpu_req = 1'b0;
        #1;
        chk("t3_end_gnt", bus.o_dma_gnt, 0);
        tick;

        // 18-word DMA burst with idle CPU: counter wraps, no break
        bus.i_dma_req  = 1'b1;
        bus.i_dma_addr = 32'h200;
        #1;
        chk("t4_pre_stall", bus.o_cpu_stall, 0);
        chk("t4_pre_gnt", bus.o_dma_gnt, 0);
        for (int k = 0; k < 18; k++) begin
            tick;
            bus.i_dma_addr  = 32'h200 + 4 * k;
            bus.i_dma_wdata = 32'hB0000000 + k;
            #1;
            chk("t4_gnt", bus.o_dma_gnt, 1);
            chk("t4_stall", bus.o_cpu_stall, 1);
        end
        tick;
        bus.i_dma_req = 1'b0;
        #1;
        chk("t4_word17", mem[145], 32'hB0000011);
        tick;
        bus.i_cpu_req  = 1'b1;
        bus.i_cpu_addr = 32'h10;
        tick;
        bus.i_cpu_req = 1'b0;
        #1;
        chk("t4_cpu_read", bus.o_cpu_rdata, 32'hCAFEF00D);

        // DMA read: one-cycle return, CPU data untouched
        tick;
        bus.i_dma_req  = 1'b1;
        bus.i_dma_we   = 1'b0;
        bus.i_dma_addr = 32'h40;
        #1;
        chk("t5_pre_gnt", bus.o_dma_gnt, 0);
        tick;
        #1;
        chk("t5_gnt", bus.o_dma_gnt, 1);
        chk("t5_mem_wb", bus.o_mem_wb, 0);
        chk("t5_valid0", bus.o_dma_valid, 0);
        tick;
        bus.i_dma_req = 1'b0;
        #1;
        chk("t5_valid1", bus.o_dma_valid, 1);
        chk("t5_dma_data", bus.o_dma_rdata, 32'hDEADBEEF);
        chk("t5_cpu_data", bus.o_cpu_rdata, 32'hCAFEF00D);
        tick;
        #1;
        chk("t5_valid2", bus.o_dma_valid, 0);

        // Asynchronous reset in the middle of a DMA read burst
        tick;
        bus.i_dma_req  = 1'b1;
        bus.i_dma_addr = 32'h44;
        tick;
        #1;
        chk("t6_gnt", bus.o_dma_gnt, 1);
        tick;
        #1;
        chk("t6_valid", bus.o_dma_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_en", bus.o_mem_en, 0);
        chk("t6_rst_stall", bus.o_cpu_stall, 1);
        chk("t6_rst_valid", bus.o_dma_valid, 0);
        chk("t6_rst_gnt", bus.o_dma_gnt, 0);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_post_stall", bus.o_cpu_stall, 0);
        chk("t6_post_gnt", bus.o_dma_gnt, 0);
        chk("t6_post_valid", bus.o_dma_valid, 0);
        tick;
        bus.i_dma_req = 1'b0;
        #1;
        chk("t6_post_valid2", bus.o_dma_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
